top_conv_engine: RTL and testbench
==================================

# top_conv_engine

Streaming 3×3 convolution engine for the first CNN layer. It takes one byte per clock on `i_data`: 18 signed weights for two filters, then 24 pixel bands of a 26×26 unsigned image. It applies both filters with a ReLU and streams 8-bit results on `o_data`. It sits between the pixel/weight feeder and the downstream pooling stage.

## Interface
- No parameters; geometry is fixed: 26×26 input, 24×24 output, 2 filters per frame.
- `clk` in 1: clock; all activity on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `layer_num` in 2: layer select; only 0 is supported.
- `i_data` in 8: weight byte (signed) or pixel byte (unsigned); sampled on every rising edge with `rst_n`=1.
- `o_data` out 8: registered result byte.

## Operation
- The frame is a fixed sequence of sampled bytes, tracked by a phase counter:
  - WEIGHT: 18 cycles (W0–W17). Bytes 0–8 are filter A, row-major (w0 is the top-left tap). Bytes 9–17 are filter B.
  - BAND n (n=0..23): 79 cycles, b=0..78.
    - b=0..25: image row n, columns 0..25.
    - b=26..51: row n+1.
    - b=52..77: row n+2.
    - b=78: gap; the input is ignored.
  - DRAIN: 24 cycles (D0–D23); the input is ignored. Then return to W0 for the next frame.
- Storage:
  - Two 26-byte line buffers hold rows n and n+1.
  - A 3-column sliding window is fed while row n+2 streams in.
- Result for column k of band n, per filter:
  - Product term: p_i = weight_i (signed 8) × pixel (unsigned 8), exact, then truncated to its low 15 bits and read as 15-bit two's complement (deliberate wrap).
  - Sum: sign-extend the nine p_i to 21 bits and add, giving S.
  - ReLU: if S[20]=1, then S=0.
  - Output byte: S[15:8]. Higher bits are dropped, with no saturation.
- The result for column k completes when row n+2, column c=k+2 is sampled (b=52+c, c=2..25).
  - Filter A goes straight to `o_data`.
  - Filter B is written into a 24-entry byte buffer BB[k].
- `o_data` register update, for each sampling edge:
  - Weight edges: 0.
  - Band n, b=0..23: BB[b] from band n−1. Band 0 gives 0.
  - b=24..53: 0.
  - b=54..77: filter-A byte for column b−54 of band n.
  - b=78: 0.
  - DRAIN Dk: BB[k] from band 23.
- BB is not read at the same edge it is written, because the read and write windows do not overlap.
- `layer_num`≠0: the FSM is held at W0 and `o_data`=0. Returning to 0 starts a new frame at W0.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - Phase goes to W0, counters clear, `o_data`=0.
  - Line buffers and BB contents are don't-care.
- The first edge with `rst_n`=1 samples weight byte 0.
- Reset mid-frame aborts the frame; the next sampled byte is weight byte 0.
- Latency: the filter-A byte for column k appears on `o_data` one cycle after row n+2, column k+2 is sampled.
- There is no handshake; the input cadence is fixed.
- Frame length: 18 + 24×79 + 24 = 1938 sampled cycles.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with random `i_data` → `o_data`=0. After release, send 18 weights and check the first band's b=0..53 outputs are 0.
- Filter A center tap w4=0x40 (others 0), all pixels 200 → each filter-A output is 12800=0x3200, so `o_data`=0x32 at b=55..78 of every band.
- Column alignment: A w0=0x40 (others 0), row-n pixel value = 8×column → band-0 filter-A outputs are 0,2,4,…,46 in order.
- Filter B with all nine weights 0x40, pixels 255 → S=0x23DC0. BB bytes are 0x3D, appearing at band n+1 b=0..23, and at D0–D23 after band 23.
- Wrap and ReLU:
  - Filter A w0=127 (others 0), pixel 255 → 32385 wraps to negative → 0.
  - Filter B all weights 0xFF, pixels 10 → −90 → 0.
- Mid-band reset (band 5, b=30), then a fresh frame with the center-tap setup → outputs match a clean run. `layer_num`=1 → `o_data` stays 0.

Source files
------------

// File: rtl/top_conv_engine.sv
// rtl/top_conv_engine.sv - streaming 3x3 two-filter convolution engine with ReLU, 26x26 in / 24x24 out
module top_conv_engine (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] layer_num,
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);

  typedef enum logic [1:0] {
    S_WEIGHT = 2'd0,
    S_BAND   = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  // Position within the frame: r_col counts weights, columns and drain slots;
  // r_seg selects row n (0), row n+1 (1), row n+2 (2) or the band gap (3).
  state_t       r_state;
  logic [4:0]   r_col;
  logic [1:0]   r_seg;
  logic [4:0]   r_band;
  logic [7:0]   r_data;

  // Weight byte i ends up at r_wgt[8*i +: 8]; filter A is the low 72 bits.
  logic [143:0] r_wgt;
  logic [7:0]   r_lb0 [26];
  logic [7:0]   r_lb1 [26];
  logic [7:0]   r_bb  [24];
  // Sliding window, two columns per row: r_win[2*row] is column c-2, r_win[2*row+1] is c-1.
  logic [7:0]   r_win [6];

  logic         w_run;
  logic         w_win_valid;
  logic [4:0]   w_k;
  logic [71:0]  w_pix;
  logic [7:0]   w_res_a;
  logic [7:0]   w_res_b;

  // Nine wrapped 15-bit products summed in 21 bits, ReLU, then bits [15:8].
  function automatic logic [7:0] conv_byte(input logic [71:0] w, input logic [71:0] p);
    logic [14:0] prod;
    logic [20:0] sum;
    sum = '0;
    for (int i = 0; i < 9; i++) begin
      prod = {{7{w[8*i+7]}}, w[8*i +: 8]} * {7'd0, p[8*i +: 8]};
      sum  = sum + {{6{prod[14]}}, prod};
    end
    return sum[20] ? 8'd0 : sum[15:8];
  endfunction

  assign o_data      = r_data;
  assign w_run       = rst_n && (layer_num == 2'd0);
  assign w_win_valid = (r_seg == 2'd2) && (r_col >= 5'd2);
  assign w_k         = r_col - 5'd2;
  // Tap 0 is top-left (row n, column c-2); tap 8 is the pixel being sampled now.
  assign w_pix       = {i_data, r_win[5], r_win[4],
                        r_lb1[r_col], r_win[3], r_win[2],
                        r_lb0[r_col], r_win[1], r_win[0]};
  assign w_res_a     = conv_byte(r_wgt[71:0], w_pix);
  assign w_res_b     = conv_byte(r_wgt[143:72], w_pix);

  // Frame sequencer and registered output byte.
  always_ff @(posedge clk) begin
    if (!rst_n || (layer_num != 2'd0)) begin
      r_state <= S_WEIGHT;
      r_col   <= '0;
      r_seg   <= '0;
      r_band  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_WEIGHT: begin
          r_data <= '0;
          if (r_col == 5'd17) begin
            r_state <= S_BAND;
            r_col   <= '0;
            r_seg   <= '0;
            r_band  <= '0;
          end else begin
            r_col <= r_col + 5'd1;
          end
        end
        S_BAND: begin
          if ((r_seg == 2'd0) && (r_col < 5'd24) && (r_band != 5'd0))
            r_data <= r_bb[r_col];
          else if (w_win_valid)
            r_data <= w_res_a;
          else
            r_data <= '0;
          if (r_seg == 2'd3) begin
            r_seg <= '0;
            r_col <= '0;
            if (r_band == 5'd23) begin
              r_state <= S_DRAIN;
            end else begin
              r_band <= r_band + 5'd1;
            end
          end else if ((r_seg != 2'd3) && (r_col == 5'd25)) begin
            r_col <= '0;
            r_seg <= r_seg + 2'd1;
          end else begin
            r_col <= r_col + 5'd1;
          end
        end
        S_DRAIN: begin
          r_data <= r_bb[r_col];
          if (r_col == 5'd23) begin
            r_state <= S_WEIGHT;
            r_col   <= '0;
          end else begin
            r_col <= r_col + 5'd1;
          end
        end
        default: begin
          r_state <= S_WEIGHT;
          r_col   <= '0;
          r_data  <= '0;
        end
      endcase
    end
  end

  // Weight capture, line buffers, sliding window and filter-B result buffer.
  always_ff @(posedge clk) begin
    if (w_run) begin
      if (r_state == S_WEIGHT)
        r_wgt <= {i_data, r_wgt[143:8]};
      if (r_state == S_BAND) begin
        case (r_seg)
          2'd0: r_lb0[r_col] <= i_data;
          2'd1: r_lb1[r_col] <= i_data;
          2'd2: begin
            r_win[0] <= r_win[1];
            r_win[1] <= r_lb0[r_col];
            r_win[2] <= r_win[3];
            r_win[3] <= r_lb1[r_col];
            r_win[4] <= r_win[5];
            r_win[5] <= i_data;
            if (w_win_valid)
              r_bb[w_k] <= w_res_b;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_top_conv_engine.sv
// tb/tb_top_conv_engine.sv - randomized frame-level check of top_conv_engine against an arithmetic model
module tb_top_conv_engine;

  localparam int FRAME  = 1938;
  localparam int DRAIN0 = 18 + 24 * 79;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] layer_num = 2'd0;
  logic [7:0] i_data = 8'd0;
  logic [7:0] o_data;

  int         n_checks = 0;
  int         n_errors = 0;
  int         wgt [18];
  int         img [26][26];
  logic [7:0] obs [FRAME];

  always #5 clk = ~clk;

  top_conv_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .layer_num (layer_num),
    .i_data    (i_data),
    .o_data    (o_data)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Result byte of filter f for output row n, column k, straight from the arithmetic rules.
  function automatic int conv(input int f, input int n, input int k);
    int s;
    int p;
    s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        p = (wgt[f*9 + r*3 + c] * img[n+r][k+c]) & 32'h7FFF;
        if (p >= 16384) p = p - 32768;
        s = s + p;
      end
    if (s < 0) return 0;
    return (s >> 8) & 255;
  endfunction

  function automatic logic [7:0] expect_at(input int j);
    int n;
    int b;
    if (j < 18) return 8'd0;
    if (j >= DRAIN0) return 8'(conv(1, 23, j - DRAIN0));
    n = (j - 18) / 79;
    b = (j - 18) % 79;
    if (b < 24) return (n == 0) ? 8'd0 : 8'(conv(1, n - 1, b));
    if (b >= 54 && b <= 77) return 8'(conv(0, n, b - 54));
    return 8'd0;
  endfunction

  function automatic logic [7:0] stim_byte(input int j);
    int n;
    int b;
    if (j < 18) return 8'(wgt[j]);
    if (j >= DRAIN0) return 8'($urandom);
    n = (j - 18) / 79;
    b = (j - 18) % 79;
    if (b < 26) return 8'(img[n][b]);
    if (b < 52) return 8'(img[n+1][b-26]);
    if (b < 78) return 8'(img[n+2][b-52]);
    return 8'($urandom);
  endfunction

  task automatic step(input logic [7:0] d);
    @(negedge clk);
    i_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_w();
    for (int i = 0; i < 18; i++) wgt[i] = 0;
  endtask

  task automatic fill_img(input int v);
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 26; c++)
        img[r][c] = (v < 0) ? int'($urandom_range(0, 255)) : v;
  endtask

  task automatic rand_w(input int first, input int last);
    for (int i = first; i <= last; i++) wgt[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  // Streams one frame (or up to and including edge abort_at) and checks every output byte.
  task automatic run_frame(input int abort_at);
    bit done;
    done = 1'b0;
    for (int j = 0; j < FRAME && !done; j++) begin
      step(stim_byte(j));
      obs[j] = o_data;
      chk($sformatf("frame_edge%0d", j), o_data, expect_at(j));
      if (j == abort_at) done = 1'b1;
    end
  endtask

  initial begin
    // Reset with random input bytes.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(8'($urandom));
      chk("reset", o_data, 8'd0);
    end
    rst_n = 1'b1;

    // Filter A centre tap, flat image.
    clear_w(); wgt[4] = 64; rand_w(9, 17); fill_img(200);
    run_frame(-1);
    for (int k = 0; k < 54; k++) chk("band0_quiet", obs[18 + k], 8'd0);
    for (int n = 0; n < 24; n += 11) chk("center_a", obs[18 + 79*n + 54], 8'h32);

    // Column alignment through the top-left tap.
    clear_w(); wgt[0] = 64;
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 26; c++) img[r][c] = 8 * c;
    run_frame(-1);
    for (int k = 0; k < 24; k++) chk("align", obs[18 + 54 + k], 8'(2 * k));

    // Filter B via the result buffer and drain.
    clear_w(); for (int i = 9; i < 18; i++) wgt[i] = 64; fill_img(255);
    run_frame(-1);
    chk("bb_band", obs[18 + 79 + 5], 8'h3D);
    chk("bb_drain0", obs[DRAIN0], 8'h3D);
    chk("bb_drain23", obs[DRAIN0 + 23], 8'h3D);

    // Product wrap on filter A, negative sum on filter B.
    clear_w(); wgt[0] = 127; fill_img(255);
    run_frame(-1);
    chk("wrap_a", obs[18 + 54 + 3], 8'd0);
    clear_w(); for (int i = 9; i < 18; i++) wgt[i] = -1; fill_img(10);
    run_frame(-1);
    chk("relu_b", obs[DRAIN0 + 4], 8'd0);

    // Random frames.
    for (int f = 0; f < 2; f++) begin
      rand_w(0, 17); fill_img(-1);
      run_frame(-1);
    end

    // Reset in the middle of band 5, then a clean centre-tap frame.
    rand_w(0, 17); fill_img(-1);
    run_frame(18 + 5*79 + 30);
    rst_n = 1'b0;
    step(8'($urandom));
    chk("mid_reset", o_data, 8'd0);
    rst_n = 1'b1;
    clear_w(); wgt[4] = 64; rand_w(9, 17); fill_img(200);
    run_frame(-1);
    chk("after_reset_a", obs[18 + 79*3 + 60], 8'h32);

    // Unsupported layer holds the engine idle.
    layer_num = 2'd1;
    for (int i = 0; i < 16; i++) begin
      step(8'($urandom));
      chk("layer_idle", o_data, 8'd0);
    end
    layer_num = 2'd0;
    rand_w(0, 17); fill_img(-1);
    run_frame(18 + 2*79 + 60);
    layer_num = 2'd2;
    for (int i = 0; i < 4; i++) begin
      step(8'($urandom));
      chk("layer_abort", o_data, 8'd0);
    end
    layer_num = 2'd0;
    rand_w(0, 17); fill_img(-1);
    run_frame(-1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
